// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - shared state encoding, command record and default widths
// for the Wishbone classic command master.
package wb_master_pkg;

  localparam int unsigned WB_AW          = 32;
  localparam int unsigned WB_DW          = 32;
  localparam int unsigned WB_SW          = WB_DW / 8;
  localparam int unsigned WB_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
  } cmd_t;

endpackage

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - command stream to single Wishbone B3 classic cycles
// Optional ack-timeout abort is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int unsigned AW          = WB_AW,
  parameter int unsigned DW          = WB_DW,
  parameter int unsigned TIMEOUT_CYC = WB_TIMEOUT_CYC
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  localparam int unsigned SW = DW / 8;

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TW-1:0] timer_q, timer_d;
  logic          rsp_err_q, rsp_err_d;
  logic          expired;

  assign expired = (timer_q == TW'(TIMEOUT_CYC));

  // Outside BUS the timer rests at zero, so it is already cleared on BUS entry.
  always_comb begin
    timer_d = '0;
    if ((state_q == ST_BUS) && !wbm_ack_i) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      timer_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign rsp_err            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // An ack on the expiry cycle takes priority over the abort.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = ST_RESP;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (expired) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  // Ready is masked during reset so nothing is accepted in the reset cycle.
  assign cmd_ready = (state_q == ST_IDLE) && !wb_rst_i;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master with a behavioural
// slave and a queue-based reference model; timeout scenario under WB_MASTER_TIMEOUT_EN.
module tb_wb_cmd_master;
  import wb_master_pkg::*;

  localparam int unsigned TO_CYC = 8;

  logic        clk;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  logic        slave_en      = 1'b0;
  logic        slave_force   = 1'b0;
  logic        slave_ovr     = 1'b0;
  logic        slave_rand    = 1'b0;
  logic [31:0] slave_ovr_dat = '0;
  int          slave_wait    = 0;
  int          slave_cnt     = 0;

  wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Read data the slave returns for an address when no override is set.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Slave: acks after slave_wait wait states; write acks carry junk data.
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      wbm_ack_i = 1'b0;
      wbm_dat_i = '0;
      if (slave_force) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hBAD0_BAD0;
      end else if (slave_en && wbm_cyc_o && wbm_stb_o) begin
        if (slave_cnt >= slave_wait) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = wbm_we_o ? 32'hFFFF_FFFF : (slave_ovr ? slave_ovr_dat : rd_model(wbm_adr_o));
          slave_cnt = 0;
          if (slave_rand) slave_wait = $urandom_range(0, 3);
        end else begin
          slave_cnt++;
        end
      end else begin
        slave_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    int t;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL send_cmd: cmd_ready never rose within 100 cycles");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int ncyc, output bit fld_ok,
                          output bit rdy_ok, output bit got);
    ncyc = 0; fld_ok = 1'b1; rdy_ok = 1'b1; got = 1'b0;
    for (int t = 0; t < 64 && !got; t++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        if (wbm_cyc_o === 1'b1) begin
          ncyc++;
          if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
              wbm_dat_o !== dat || wbm_sel_o !== sel) fld_ok = 1'b0;
        end
        if (cmd_ready !== 1'b0) rdy_ok = 1'b0;
        @(negedge clk);
      end
    end
    if (rsp_valid === 1'b1 && cmd_ready !== 1'b0) rdy_ok = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_flags: got valid=%b err=%b want 0/0", rsp_valid, rsp_err); end
    checks++; if (rsp_dat !== 32'h0) begin errors++; $display("FAIL reset_rsp_dat: got %h want 0", rsp_dat); end
    checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000) begin errors++; $display("FAIL reset_bus_ctl: got %b want 000", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
    checks++; if ({wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 68'h0) begin errors++; $display("FAIL reset_bus_data: got adr=%h dat=%h sel=%h want 0", wbm_adr_o, wbm_dat_o, wbm_sel_o); end
    wb_rst_i = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    int ncyc; bit fok, rok, got;
    slave_en = 1'b1; slave_wait = 1; slave_ovr = 1'b0;
    send_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, ncyc, fok, rok, got);
    checks++; if (!got) begin errors++; $display("FAIL write_rsp_seen: got no rsp_valid want rsp_valid"); end
    checks++; if (ncyc != 2) begin errors++; $display("FAIL write_cyc_len: got %0d want 2", ncyc); end
    checks++; if (!fok) begin errors++; $display("FAIL write_bus_fields: got mismatching wbm_* want cmd fields"); end
    checks++; if (!rok) begin errors++; $display("FAIL write_ready_low: got cmd_ready high want low while busy"); end
    checks++; if (rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin errors++; $display("FAIL write_rsp: got err=%b dat=%h want 0/0", rsp_err, rsp_dat); end
    take_rsp();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL write_release: got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_read();
    int ncyc; bit fok, rok, got, hold_ok;
    logic [31:0] d;
    slave_en = 1'b1; slave_wait = 3; slave_ovr = 1'b1; slave_ovr_dat = 32'h1234_5678;
    d = $urandom();
    send_cmd(1'b0, 32'h3000_0008, d, 4'hF);
    wait_rsp(1'b0, 32'h3000_0008, d, 4'hF, ncyc, fok, rok, got);
    checks++; if (!got) begin errors++; $display("FAIL read_rsp_seen: got no rsp_valid want rsp_valid"); end
    checks++; if (ncyc != 4) begin errors++; $display("FAIL read_cyc_len: got %0d want 4", ncyc); end
    checks++; if (!fok) begin errors++; $display("FAIL read_bus_stable: got changing wbm_* want stable cmd fields"); end
    checks++; if (rsp_dat !== 32'h1234_5678 || rsp_err !== 1'b0) begin errors++; $display("FAIL read_rsp: got dat=%h err=%b want 12345678/0", rsp_dat, rsp_err); end
    hold_ok = rok;
    repeat (2) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) hold_ok = 1'b0;
    end
    checks++; if (!hold_ok) begin errors++; $display("FAIL read_ready_until_taken: got cmd_ready high or rsp dropped want held"); end
    take_rsp();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL read_release: got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready); end
    slave_ovr = 1'b0;
  endtask

  task automatic test_backpressure();
    int ncyc; bit fok, rok, got, held_ok;
    logic [31:0] a1, a2, d2, exp1;
    slave_en = 1'b1; slave_wait = 0;
    a1 = $urandom() & 32'hFFFF_FFFC; a2 = $urandom() & 32'hFFFF_FFFC; d2 = $urandom();
    exp1 = rd_model(a1);
    send_cmd(1'b0, a1, 32'h0, 4'h3);
    wait_rsp(1'b0, a1, 32'h0, 4'h3, ncyc, fok, rok, got);
    checks++; if (!got || rsp_dat !== exp1) begin errors++; $display("FAIL bp_first_rsp: got valid=%b dat=%h want 1/%h", got, rsp_dat, exp1); end
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = a2; cmd_dat = d2; cmd_sel = 4'hA;
    held_ok = 1'b1;
    repeat (5) begin
      if (rsp_valid !== 1'b1 || rsp_dat !== exp1 || cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) held_ok = 1'b0;
      @(negedge clk);
    end
    checks++; if (!held_ok) begin errors++; $display("FAIL bp_hold: got rsp/cmd_ready/cyc changed want held for 5 cycles"); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_after_take: got ready=%b cyc=%b valid=%b want 1/0/0", cmd_ready, wbm_cyc_o, rsp_valid); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== a2 || wbm_we_o !== 1'b1) begin errors++; $display("FAIL bp_second_issue: got cyc=%b adr=%h we=%b want 1/%h/1", wbm_cyc_o, wbm_adr_o, wbm_we_o, a2); end
    wait_rsp(1'b1, a2, d2, 4'hA, ncyc, fok, rok, got);
    checks++; if (!got || !fok || rsp_dat !== 32'h0) begin errors++; $display("FAIL bp_second_rsp: got valid=%b fields_ok=%b dat=%h want 1/1/0", got, fok, rsp_dat); end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    logic [31:0] adrs[4];
    int idx, nrsp, starts, run, maxrun, t_acc, t_rsp;
    bit acc, prev, ord_ok;
    slave_en = 1'b1; slave_wait = 0; rsp_ready = 1'b1;
    foreach (adrs[i]) adrs[i] = $urandom() & 32'hFFFF_FFFC;
    idx = 0; nrsp = 0; starts = 0; run = 0; maxrun = 0; t_acc = -1; t_rsp = -1;
    acc = 1'b0; prev = 1'b0; ord_ok = 1'b1;
    for (int t = 0; t < 80 && nrsp < 4; t++) begin
      if (acc) idx++;
      cmd_valid = (idx < 4);
      cmd_we = 1'b0; cmd_dat = 32'h0; cmd_sel = 4'hF;
      cmd_adr = (idx < 4) ? adrs[idx] : 32'h0;
      if (wbm_cyc_o === 1'b1) begin
        if (!prev) begin
          if (starts < 4 && wbm_adr_o !== adrs[starts]) ord_ok = 1'b0;
          starts++;
        end
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      prev = (wbm_cyc_o === 1'b1);
      if (rsp_valid === 1'b1) begin
        if (t_rsp < 0) t_rsp = cyc_n;
        if (nrsp < 4 && rsp_dat !== rd_model(adrs[nrsp])) ord_ok = 1'b0;
        nrsp++;
      end
      acc = cmd_valid && (cmd_ready === 1'b1);
      if (acc && t_acc < 0) t_acc = cyc_n;
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (starts != 4) begin errors++; $display("FAIL b2b_cyc_count: got %0d want 4", starts); end
    checks++; if (maxrun != 1) begin errors++; $display("FAIL b2b_cyc_len: got %0d want 1", maxrun); end
    checks++; if (nrsp != 4 || !ord_ok) begin errors++; $display("FAIL b2b_responses: got %0d in_order=%b want 4/1", nrsp, ord_ok); end
    checks++; if (t_rsp - t_acc != 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", t_rsp - t_acc); end
    @(negedge clk);
  endtask

  task automatic test_stray_ack();
    bit quiet;
    quiet = 1'b1;
    slave_force = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
    end
    slave_force = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL stray_ack_ignored: got state/output change want none"); end
  endtask

`ifdef WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int ncyc; bit fok, rok, got, held;
    logic [31:0] a;
    slave_en = 1'b0;
    a = $urandom() & 32'hFFFF_FFFC;
    send_cmd(1'b0, a, 32'h0, 4'hF);
    wait_rsp(1'b0, a, 32'h0, 4'hF, ncyc, fok, rok, got);
    // Timer starts at 0 in the first BUS cycle and aborts once it has counted up to TO_CYC.
    checks++; if (!got || ncyc != int'(TO_CYC) + 1) begin errors++; $display("FAIL timeout_cyc_len: got valid=%b cycles=%0d want 1/%0d", got, ncyc, TO_CYC + 1); end
    checks++; if (rsp_err !== 1'b1 || rsp_dat !== 32'h0) begin errors++; $display("FAIL timeout_rsp: got err=%b dat=%h want 1/0", rsp_err, rsp_dat); end
    held = 1'b1;
    slave_force = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0 || wbm_cyc_o !== 1'b0) held = 1'b0;
    end
    slave_force = 1'b0;
    @(negedge clk);
    checks++; if (!held) begin errors++; $display("FAIL timeout_late_ack: got response changed want held"); end
    take_rsp();
    slave_en = 1'b1; slave_wait = 1;
    send_cmd(1'b0, a, 32'h0, 4'hF);
    wait_rsp(1'b0, a, 32'h0, 4'hF, ncyc, fok, rok, got);
    checks++; if (!got || rsp_err !== 1'b0 || rsp_dat !== rd_model(a)) begin errors++; $display("FAIL timeout_recover: got err=%b dat=%h want 0/%h", rsp_err, rsp_dat, rd_model(a)); end
    take_rsp();
  endtask
`endif

  task automatic test_reset_mid_bus();
    int ncyc; bit fok, rok, got, silent;
    logic [31:0] a;
    slave_en = 1'b0;
    send_cmd(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'h5);
    checks++; if (wbm_cyc_o !== 1'b1) begin errors++; $display("FAIL rst_bus_started: got cyc=%b want 1", wbm_cyc_o); end
    @(negedge clk);
    wb_rst_i = 1'b1;
    @(negedge clk);
    checks++; if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready} !== 4'b0000) begin errors++; $display("FAIL rst_mid_bus_drop: got cyc,stb,valid,ready=%b want 0000", {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready}); end
    wb_rst_i = 1'b0;
    silent = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) silent = 1'b0;
    end
    checks++; if (!silent) begin errors++; $display("FAIL rst_no_response: got rsp_valid or cyc after reset want none"); end
    slave_en = 1'b1; slave_wait = 2;
    a = $urandom() & 32'hFFFF_FFFC;
    send_cmd(1'b0, a, 32'h0, 4'hC);
    wait_rsp(1'b0, a, 32'h0, 4'hC, ncyc, fok, rok, got);
    checks++; if (!got || ncyc != 3 || rsp_dat !== rd_model(a) || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_recover: got valid=%b cycles=%0d dat=%h want 1/3/%h", got, ncyc, rsp_dat, rd_model(a)); end
    take_rsp();
  endtask

  task automatic test_random();
    cmd_t cmds[$];
    cmd_t c;
    logic [31:0] exp;
    int idx, bus_i, nrsp;
    bit acc, prev, bus_ok;
    for (int i = 0; i < 20; i++) begin
      c.we = $urandom_range(0, 1);
      c.adr = $urandom() & 32'hFFFF_FFFC;
      c.dat = $urandom();
      c.sel = $urandom_range(1, 15);
      cmds.push_back(c);
    end
    slave_en = 1'b1; slave_rand = 1'b1; slave_wait = 0;
    idx = 0; bus_i = 0; nrsp = 0; acc = 1'b0; prev = 1'b0; bus_ok = 1'b1;
    for (int t = 0; t < 800 && nrsp < 20; t++) begin
      if (acc) begin idx++; cmd_valid = 1'b0; end
      if (!cmd_valid && idx < 20 && $urandom_range(0, 3) != 0) begin
        cmd_valid = 1'b1;
        cmd_we = cmds[idx].we; cmd_adr = cmds[idx].adr;
        cmd_dat = cmds[idx].dat; cmd_sel = cmds[idx].sel;
      end
      rsp_ready = $urandom_range(0, 1);
      if (wbm_cyc_o === 1'b1) begin
        if (!prev) bus_i++;
        if (bus_i > 20 || {wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== cmds[bus_i-1]) bus_ok = 1'b0;
      end
      prev = (wbm_cyc_o === 1'b1);
      if (rsp_valid === 1'b1 && rsp_ready) begin
        exp = cmds[nrsp].we ? 32'h0 : rd_model(cmds[nrsp].adr);
        checks++; if (rsp_dat !== exp || rsp_err !== 1'b0) begin errors++; $display("FAIL rand_rsp_%0d: got dat=%h err=%b want %h/0", nrsp, rsp_dat, rsp_err, exp); end
        nrsp++;
      end
      acc = cmd_valid && (cmd_ready === 1'b1);
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; slave_rand = 1'b0;
    checks++; if (nrsp != 20 || bus_i != 20) begin errors++; $display("FAIL rand_count: got rsp=%0d bus=%0d want 20/20", nrsp, bus_i); end
    checks++; if (!bus_ok) begin errors++; $display("FAIL rand_bus_fields: got wbm_* differing from issued cmd want equal"); end
  endtask

  initial begin
    wb_rst_i = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_stray_ack();
`ifdef WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_bus();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
